// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI frame scheduler.
// Holds the read opcode, default frame size and last sequential address.
package spi_pkg;

  localparam logic [7:0]  CMD_READ      = 8'h03;
  localparam int          DATA_SIZE_DEF = 8192;
  localparam logic [18:0] LAST_ADDR_DEF = 19'h4AC00;
  localparam int          TMO_CYCLES    = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    NEXT
  } state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Free-running scheduling tick: one-cycle pulse every PERIOD clocks.
// Counter restarts from zero on reset.
module spi_tick_gen #(
  parameter int PERIOD = 67108864
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  // wrap the period counter at PERIOD-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_frame_sched.sv
// Frame read scheduler: issues one SPI read per layer on each tick.
// Optional WAIT_START timeout: define SPI_FRAME_SCHED_TIMEOUT_EN.
module spi_frame_sched
  import spi_pkg::*;
#(
  parameter int          DATA_SIZE = DATA_SIZE_DEF,
  parameter int          PERIOD    = 67108864,
  parameter logic [18:0] LAST_ADDR = LAST_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        layered,
  input  logic [31:0] frames,
  input  logic        rd_busy,
  output logic        rd_trig,
  output logic [31:0] rd_cmd,
  output logic        rd_accumulate,
  output logic [1:0]  layer,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [18:0] FB = 19'(DATA_SIZE / 8);

  state_t      state, state_n;
  logic [1:0]  layer_n;
  logic [18:0] ptr, ptr_n;
  logic [18:0] addr, addr_n;
  logic        acc_n;
  logic        mode, mode_n;
  logic        tick;
  logic        tmo_hit;
  logic [7:0]  fbyte;

  spi_tick_gen #(
    .PERIOD(PERIOD)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

`ifdef SPI_FRAME_SCHED_TIMEOUT_EN
  logic [5:0] tmo_cnt;

  // count cycles spent waiting for the reader to raise busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt <= '0;
    else if (state == WAIT_START && !rd_busy) tmo_cnt <= tmo_cnt + 6'd1;
    else tmo_cnt <= '0;
  end

  assign tmo_hit = (state == WAIT_START) && !rd_busy
                && (tmo_cnt == 6'(TMO_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // state and per-read context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      layer         <= 2'd0;
      ptr           <= '0;
      addr          <= '0;
      rd_accumulate <= 1'b0;
      mode          <= 1'b0;
    end else begin
      state         <= state_n;
      layer         <= layer_n;
      ptr           <= ptr_n;
      addr          <= addr_n;
      rd_accumulate <= acc_n;
      mode          <= mode_n;
    end
  end

  // frame index byte for the layer about to be issued
  always_comb begin
    fbyte = frames[7:0];
    case (layer_n)
      2'd0: fbyte = frames[7:0];
      2'd1: fbyte = frames[15:8];
      2'd2: fbyte = frames[23:16];
      2'd3: fbyte = frames[31:24];
      default: fbyte = frames[7:0];
    endcase
  end

  // next-state, read context and pulse outputs
  always_comb begin
    state_n    = state;
    layer_n    = layer;
    ptr_n      = ptr;
    addr_n     = addr;
    acc_n      = rd_accumulate;
    mode_n     = mode;
    rd_trig    = 1'b0;
    frame_done = 1'b0;
    overrun    = (tick && state != IDLE) || tmo_hit;

    case (state)
      IDLE: begin
        if (tick) begin
          mode_n  = layered;
          layer_n = 2'd0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        rd_trig = 1'b1;
        state_n = WAIT_START;
      end
      WAIT_START: begin
        if (rd_busy) state_n = WAIT_DONE;
        else if (tmo_hit) state_n = IDLE;
      end
      WAIT_DONE: begin
        if (!rd_busy) state_n = NEXT;
      end
      NEXT: begin
        if (mode && layer < 2'd2) begin
          layer_n = layer + 2'd1;
          state_n = ISSUE;
        end else begin
          frame_done = 1'b1;
          state_n    = IDLE;
          if (!mode) ptr_n = (ptr >= LAST_ADDR) ? '0 : ptr + FB;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_n == ISSUE && state != ISSUE) begin
      addr_n = mode_n ? 19'(fbyte) * FB : ptr;
      acc_n  = (layer_n != 2'd0);
    end
  end

  assign rd_cmd = {CMD_READ, 5'b0, addr};

endmodule
